dc_bu_write_manager: RTL and testbench
======================================

DC_BU_WRITE_MANAGER -- requirements
Module: dc_bu_write_manager

Interface
REQ-001 SHALL have parameters:
  BUFF_ADDR_WIDTH, 7, line-buffer address width.
  BUFFER_SIZE, 128, pixels per line buffer.
  BUFFER_NUM, 5, number of line buffers.
  PIXELS_PER_LINE_WIDTH, 7, width of pixels_per_line.
  CNT_WIDTH, 3, width of lines_avail; holds 0..BUFFER_NUM.
REQ-002 SHALL have ports (one clock; reset is asynchronous and active-high):
  clk  in  1  rising-edge clock.
  rst  in  1  asynchronous active-high reset.
  en  in  1  clock enable; low freezes all state.
  frame_start  in  1  start-of-frame strobe.
  pixel_valid  in  1  incoming pixel present this cycle.
  line_end  in  1  current input line finished; coincident pixel belongs to that line.
  next_line  in  1  read side has consumed its oldest line.
  mem_addr  out  BUFF_ADDR_WIDTH  write address.
  we_vec  out  BUFFER_NUM  per-buffer write enable.
  write_buffer_id  out  BUFFER_NUM  one-hot buffer currently being written.
  pixels_per_line  out  PIXELS_PER_LINE_WIDTH  index of last pixel of last completed line.
  lines_avail  out  CNT_WIDTH  completed, unread lines.
  line_done  out  1  one-cycle pulse on line commit.
  stall  out  1  high in STALL state.
  overflow  out  1  sticky pixel-drop/underflow error.

Function
REQ-003 SHALL implement FSM states IDLE, ACTIVE, STALL; every transition and register update requires en=1.
REQ-004 IDLE -> ACTIVE on frame_start; pixel_valid, line_end, next_line ignored in IDLE.
REQ-005 frame_start in any state SHALL clear addr counter, pixel count, lines_avail, set write_buffer_id=1 (bit0), enter ACTIVE; same-cycle pixel_valid/line_end/next_line ignored.
REQ-006 In ACTIVE, pixel_valid with line_full=0 SHALL assert we_vec=write_buffer_id combinationally, write at mem_addr, then increment addr counter.
REQ-007 Addr counter SHALL saturate at BUFFER_SIZE-1; write at BUFFER_SIZE-1 sets internal line_full; further pixels in that line are dropped (we_vec=0) and set overflow.
REQ-008 we_vec SHALL be 0 whenever en=0, state is not ACTIVE, or pixel is dropped.
REQ-009 line_end in ACTIVE with at least one pixel written in the line (including coincident pixel) SHALL commit: pixels_per_line <= address of last written pixel (count-1), line_done=1 next cycle for one cycle, addr counter and line_full cleared.
REQ-010 line_end with zero pixels written SHALL be ignored (no commit, no pulse).
REQ-011 On commit lines_avail increments; if new value < BUFFER_NUM, write_buffer_id rotates left by one (bit BUFFER_NUM-1 wraps to bit0), stay ACTIVE.
REQ-012 If commit makes lines_avail==BUFFER_NUM, SHALL not rotate and enter STALL; stall=1.
REQ-013 In STALL, pixel_valid SHALL be dropped and set overflow; line_end ignored.
REQ-014 In STALL, next_line SHALL decrement lines_avail, rotate write_buffer_id, return to ACTIVE.
REQ-015 In ACTIVE, next_line SHALL decrement lines_avail; next_line with lines_avail==0 SHALL leave it 0 and set overflow.
REQ-016 Commit and next_line in same cycle SHALL leave lines_avail unchanged and rotate; no STALL entry.
REQ-017 mem_addr SHALL equal the addr counter register; write_buffer_id always exactly one-hot.
REQ-018 overflow SHALL be cleared only by rst.

Reset
REQ-019 rst=1 SHALL asynchronously force: state IDLE, mem_addr=0, we_vec=0, write_buffer_id=1, pixels_per_line=0, lines_avail=0, line_done=0, stall=0, overflow=0.
REQ-020 rst mid-line SHALL discard the partial line; after release, frame_start is required before writes.

Verification
REQ-021 Reset, frame_start, 10 pixels then line_end with 10th pixel -> we_vec=00001 addrs 0..9, pixels_per_line=9, line_done pulse, write_buffer_id=00010, lines_avail=1.
REQ-022 Five 4-pixel lines without next_line -> ids 00001..10000 used, 5th commit: lines_avail=5, stall=1, id stays 10000; next_line -> id=00001, lines_avail=4, ACTIVE.
REQ-023 130 pixels in one line -> writes to addr 0..127, 2 dropped, overflow=1, pixels_per_line=127.
REQ-024 line_end with no pixels; next_line with lines_avail=0 -> no commit, lines_avail=0, overflow=1.
REQ-025 Commit and next_line same cycle with lines_avail=4 -> lines_avail=4, rotation, stall=0.
REQ-026 en=0 during pixel stream -> we_vec=0, counters frozen; rst mid-line -> all outputs at reset values.

Source files
------------

// File: rtl/dc_bu_write_manager.sv
// Line-buffer write manager.
// Streams incoming pixels into a ring of line buffers. Completed lines are
// handed to the read side, which frees them again with next_line. Writing
// stalls while every buffer holds an unread line. A sticky overflow flag
// records dropped pixels and read-side underflow.
module dc_bu_write_manager #(
    parameter int BUFF_ADDR_WIDTH       = 7,
    parameter int BUFFER_SIZE           = 128,
    parameter int BUFFER_NUM            = 5,
    parameter int PIXELS_PER_LINE_WIDTH = 7,
    parameter int CNT_WIDTH             = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en,
    input  logic                             frame_start,
    input  logic                             pixel_valid,
    input  logic                             line_end,
    input  logic                             next_line,
    output logic [BUFF_ADDR_WIDTH-1:0]       mem_addr,
    output logic [BUFFER_NUM-1:0]            we_vec,
    output logic [BUFFER_NUM-1:0]            write_buffer_id,
    output logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
    output logic [CNT_WIDTH-1:0]             lines_avail,
    output logic                             line_done,
    output logic                             stall,
    output logic                             overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        STALL  = 2'd2
    } state_t;

    localparam logic [BUFF_ADDR_WIDTH-1:0] LastAddr  = BUFF_ADDR_WIDTH'(BUFFER_SIZE - 1);
    localparam logic [CNT_WIDTH-1:0]       LinesMax  = CNT_WIDTH'(BUFFER_NUM);
    localparam logic [BUFFER_NUM-1:0]      FirstId   = BUFFER_NUM'(1);

    state_t                             state_q, state_d;
    logic [BUFF_ADDR_WIDTH-1:0]         addr_q, addr_d;
    logic                               lineFull_q, lineFull_d;
    logic [BUFFER_NUM-1:0]              bufId_q, bufId_d;
    logic [PIXELS_PER_LINE_WIDTH-1:0]   ppl_q, ppl_d;
    logic [CNT_WIDTH-1:0]               lines_q, lines_d;
    logic                               lineDone_q, lineDone_d;
    logic                               overflow_q, overflow_d;

    logic                               pixWrite;
    logic                               pixDrop;
    logic                               anyPixel;
    logic                               commit;
    logic [BUFFER_NUM-1:0]              bufIdRot;
    logic [BUFF_ADDR_WIDTH-1:0]         lastWritten;

    // Next-state logic: frame_start has priority and restarts the frame,
    // otherwise the FSM handles pixel writes, line commits and reads.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        lineFull_d  = lineFull_q;
        bufId_d     = bufId_q;
        ppl_d       = ppl_q;
        lines_d     = lines_q;
        lineDone_d  = lineDone_q;
        overflow_d  = overflow_q;
        we_vec      = '0;
        pixWrite    = 1'b0;
        pixDrop     = 1'b0;
        anyPixel    = 1'b0;
        commit      = 1'b0;
        bufIdRot    = {bufId_q[BUFFER_NUM-2:0], bufId_q[BUFFER_NUM-1]};
        lastWritten = addr_q;

        if (en) begin
            lineDone_d = 1'b0;
            if (frame_start) begin
                state_d    = ACTIVE;
                addr_d     = '0;
                lineFull_d = 1'b0;
                lines_d    = '0;
                bufId_d    = FirstId;
            end else begin
                unique case (state_q)
                    IDLE: begin
                    end
                    ACTIVE: begin
                        pixWrite = pixel_valid && !lineFull_q;
                        pixDrop  = pixel_valid && lineFull_q;
                        if (pixWrite) begin
                            we_vec = bufId_q;
                            if (addr_q == LastAddr) begin
                                lineFull_d = 1'b1;
                            end else begin
                                addr_d = addr_q + 1'b1;
                            end
                        end
                        if (pixDrop) begin
                            overflow_d = 1'b1;
                        end
                        anyPixel = lineFull_q || (addr_q != '0) || pixWrite;
                        commit   = line_end && anyPixel;
                        if (commit) begin
                            // Saturated counter already points at the last
                            // written pixel; otherwise it points one past it.
                            lastWritten = (pixWrite || lineFull_q) ? addr_q : addr_q - 1'b1;
                            ppl_d       = PIXELS_PER_LINE_WIDTH'(lastWritten);
                            addr_d      = '0;
                            lineFull_d  = 1'b0;
                            lineDone_d  = 1'b1;
                        end
                        unique case ({commit, next_line})
                            2'b11: bufId_d = bufIdRot;
                            2'b10: begin
                                lines_d = lines_q + 1'b1;
                                if (lines_q + 1'b1 == LinesMax) begin
                                    state_d = STALL;
                                end else begin
                                    bufId_d = bufIdRot;
                                end
                            end
                            2'b01: begin
                                if (lines_q == '0) begin
                                    overflow_d = 1'b1;
                                end else begin
                                    lines_d = lines_q - 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                    STALL: begin
                        if (pixel_valid) begin
                            overflow_d = 1'b1;
                        end
                        if (next_line) begin
                            lines_d = lines_q - 1'b1;
                            bufId_d = bufIdRot;
                            state_d = ACTIVE;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            lineFull_q <= 1'b0;
            bufId_q    <= FirstId;
            ppl_q      <= '0;
            lines_q    <= '0;
            lineDone_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            lineFull_q <= lineFull_d;
            bufId_q    <= bufId_d;
            ppl_q      <= ppl_d;
            lines_q    <= lines_d;
            lineDone_q <= lineDone_d;
            overflow_q <= overflow_d;
        end
    end

    assign mem_addr        = addr_q;
    assign write_buffer_id = bufId_q;
    assign pixels_per_line = ppl_q;
    assign lines_avail     = lines_q;
    assign line_done       = lineDone_q;
    assign stall           = (state_q == STALL);
    assign overflow        = overflow_q;

endmodule

// File: tb/tb_dc_bu_write_manager.sv
// Testbench for dc_bu_write_manager: table-driven vectors plus
// hand-written multi-cycle sequences (stall, saturation, reset).
module tb_dc_bu_write_manager;

   logic       clk;
   logic       rst;
   logic       en;
   logic       frameStart;
   logic       pixelValid;
   logic       lineEnd;
   logic       nextLine;
   logic [6:0] memAddr;
   logic [4:0] weVec;
   logic [4:0] writeBufferId;
   logic [6:0] pixelsPerLine;
   logic [2:0] linesAvail;
   logic       lineDone;
   logic       stallOut;
   logic       overflowOut;

   int checks;
   int failures;

   typedef struct {
      logic       fs, pv, le, nl, en;
      logic [4:0] we;
      logic [6:0] addr;
      logic [4:0] id;
      logic [6:0] ppl;
      logic [2:0] la;
      logic       ld, st, ov;
   } vec_t;

   vec_t vecs[22];

   dc_bu_write_manager dut (
      .clk             (clk),
      .rst             (rst),
      .en              (en),
      .frame_start     (frameStart),
      .pixel_valid     (pixelValid),
      .line_end        (lineEnd),
      .next_line       (nextLine),
      .mem_addr        (memAddr),
      .we_vec          (weVec),
      .write_buffer_id (writeBufferId),
      .pixels_per_line (pixelsPerLine),
      .lines_avail     (linesAvail),
      .line_done       (lineDone),
      .stall           (stallOut),
      .overflow        (overflowOut)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison with pass/fail bookkeeping.
   task automatic checkOutput(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs at posedge+1 and settle to posedge+4.
   task automatic applyStimulus(input logic f, input logic p, input logic l,
                                input logic n, input logic e);
      frameStart = f;
      pixelValid = p;
      lineEnd    = l;
      nextLine   = n;
      en         = e;
      #3;
   endtask

   // Advance to just after the next rising edge.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Compare every output against a full expected record.
   task automatic checkAll(input string tag, input vec_t v);
      checkOutput({tag, ".we"},   int'(weVec),         int'(v.we));
      checkOutput({tag, ".addr"}, int'(memAddr),       int'(v.addr));
      checkOutput({tag, ".id"},   int'(writeBufferId), int'(v.id));
      checkOutput({tag, ".ppl"},  int'(pixelsPerLine), int'(v.ppl));
      checkOutput({tag, ".la"},   int'(linesAvail),    int'(v.la));
      checkOutput({tag, ".ld"},   int'(lineDone),      int'(v.ld));
      checkOutput({tag, ".st"},   int'(stallOut),      int'(v.st));
      checkOutput({tag, ".ov"},   int'(overflowOut),   int'(v.ov));
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(input logic f, p, l, n, e,
                               input logic [4:0] we, input logic [6:0] addr,
                               input logic [4:0] id, input logic [6:0] ppl,
                               input logic [2:0] la, input logic ld, st, ov);
      vec_t v;
      v.fs = f; v.pv = p; v.le = l; v.nl = n; v.en = e;
      v.we = we; v.addr = addr; v.id = id; v.ppl = ppl;
      v.la = la; v.ld = ld; v.st = st; v.ov = ov;
      return v;
   endfunction

   // Main test sequence.
   initial begin
      vec_t rv;
      checks   = 0;
      failures = 0;
      rst        = 1'b1;
      en         = 1'b0;
      frameStart = 1'b0;
      pixelValid = 1'b0;
      lineEnd    = 1'b0;
      nextLine   = 1'b0;

      // Expected outputs are those seen during the cycle the inputs are applied.
      vecs[0] = mk(1,0,0,0,1, 5'b00000, 7'd0, 5'b00001, 7'd0, 3'd0, 0,0,0);
      for (int i = 1; i <= 9; i++)
         vecs[i] = mk(0,1,0,0,1, 5'b00001, 7'(i-1), 5'b00001, 7'd0, 3'd0, 0,0,0);
      vecs[10] = mk(0,1,1,0,1, 5'b00001, 7'd9, 5'b00001, 7'd0, 3'd0, 0,0,0);
      vecs[11] = mk(0,0,0,0,1, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd1, 1,0,0);
      vecs[12] = mk(0,0,0,0,1, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd1, 0,0,0);
      vecs[13] = mk(0,0,1,0,1, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd1, 0,0,0);
      vecs[14] = mk(0,0,0,1,1, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd1, 0,0,0);
      vecs[15] = mk(0,0,0,1,1, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd0, 0,0,0);
      vecs[16] = mk(0,0,0,0,1, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd0, 0,0,1);
      vecs[17] = mk(0,1,0,0,0, 5'b00000, 7'd0, 5'b00010, 7'd9, 3'd0, 0,0,1);
      vecs[18] = mk(0,1,0,0,1, 5'b00010, 7'd0, 5'b00010, 7'd9, 3'd0, 0,0,1);
      vecs[19] = mk(0,1,0,0,0, 5'b00000, 7'd1, 5'b00010, 7'd9, 3'd0, 0,0,1);
      vecs[20] = mk(0,1,0,0,0, 5'b00000, 7'd1, 5'b00010, 7'd9, 3'd0, 0,0,1);
      vecs[21] = mk(0,0,0,0,1, 5'b00000, 7'd1, 5'b00010, 7'd9, 3'd0, 0,0,1);

      // Reset values while reset is held.
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkAll("reset", mk(0,0,0,0,0, 5'b0, 7'd0, 5'b00001, 7'd0, 3'd0, 0,0,0));
      stepCycle();
      rst = 1'b0;

      // Table: 10-pixel line, empty line_end, underflow, enable gating.
      for (int i = 0; i < 22; i++) begin
         applyStimulus(vecs[i].fs, vecs[i].pv, vecs[i].le, vecs[i].nl, vecs[i].en);
         checkAll($sformatf("vec%0d", i), vecs[i]);
         stepCycle();
      end

      // Five 4-pixel lines fill every buffer and stall.
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      for (int k = 0; k < 5; k++) begin
         for (int p = 0; p < 4; p++) begin
            applyStimulus(1'b0, 1'b1, p == 3, 1'b0, 1'b1);
            checkOutput($sformatf("fill%0d.we", k), int'(weVec), 1 << k);
            checkOutput($sformatf("fill%0d.addr", k), int'(memAddr), p);
            stepCycle();
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkAll("stalled", mk(0,0,0,0,0, 5'b0, 7'd0, 5'b10000, 7'd3, 3'd5, 1,1,0));
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("stallDrop.ov", int'(overflowOut), 1);
      checkOutput("stallDrop.st", int'(stallOut), 1);
      stepCycle();
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      checkAll("unstall", mk(0,0,0,0,0, 5'b00001, 7'd0, 5'b00001, 7'd3, 3'd4, 0,0,1));
      stepCycle();
      // Commit coincident with next_line at lines_avail=4.
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      checkOutput("commitRead.we", int'(weVec), 1);
      checkOutput("commitRead.addr", int'(memAddr), 1);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkAll("commitRead", mk(0,0,0,0,0, 5'b0, 7'd0, 5'b00010, 7'd1, 3'd4, 1,0,1));
      stepCycle();

      // 130 pixels in one line: 128 written, 2 dropped.
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      for (int i = 0; i < 130; i++) begin
         applyStimulus(1'b0, 1'b1, i == 129, 1'b0, 1'b1);
         if (i < 128) begin
            checkOutput("sat.we", int'(weVec), 1);
            checkOutput("sat.addr", int'(memAddr), i);
         end else begin
            checkOutput("satDrop.we", int'(weVec), 0);
            checkOutput("satDrop.addr", int'(memAddr), 127);
         end
         if (i == 128) checkOutput("satPre.ov", int'(overflowOut), 0);
         stepCycle();
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkAll("sat", mk(0,0,0,0,0, 5'b0, 7'd0, 5'b00010, 7'd127, 3'd1, 1,0,1));
      stepCycle();

      // Reset mid-line discards the partial line; no writes until frame_start.
      doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      stepCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
         stepCycle();
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      rst = 1'b1;
      #1;
      checkAll("midReset", mk(0,0,0,0,0, 5'b0, 7'd0, 5'b00001, 7'd0, 3'd0, 0,0,0));
      stepCycle();
      rst = 1'b0;
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      checkOutput("postReset.we", int'(weVec), 0);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("postReset.addr", int'(memAddr), 0);
      checkOutput("postReset.ld", int'(lineDone), 0);
      checkOutput("postReset.la", int'(linesAvail), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
